prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the instruction memory: receives a program image over a UART serial line and writes it word-by-word into the instruction ROM write port. The instruction fetch unit is the reader of that ROM.
- Holds the CPU in reset while loading is in progress.
- Releases the CPU once the declared number of words has been written.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 115_200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer division.
- ADDR_WIDTH, 14, instruction-memory word-address width (16384 words, 64 KB).
- DATA_WIDTH, 32, word width; equals ISA_WIDTH.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- load_en  in  1  load-mode switch; 1 = accept an image.
- uart_rx  in  1  serial input; idle high; 8N1, LSB first.
- wr_en  out  1  one-cycle instruction-memory write strobe.
- wr_addr  out  ADDR_WIDTH  word address for wr_en.
- wr_data  out  DATA_WIDTH  word data for wr_en.
- cpu_hold  out  1  1 = CPU must be held in reset.
- done  out  1  image fully written; stays high until load_en falls.
- err  out  1  sticky error (framing error or oversize count); cleared in IDLE.

Behaviour:
- Reset (reset=0): state IDLE. wr_en, cpu_hold, done and err are 0. wr_addr and wr_data are 0. Word count and byte index are 0.
- uart_rx passes through a 2-flop synchronizer before any use.
- Byte receiver (sub-module):
  - A falling edge while idle starts a frame.
  - The start bit is re-checked at CLKS_PER_BIT/2. If uart_rx is high there, the frame is a glitch: return to idle silently.
  - Data bits are sampled every CLKS_PER_BIT after that.
  - The stop bit is sampled one period after bit 7. Stop=1 gives a one-cycle byte_valid with the byte. Stop=0 gives a one-cycle frame_err and no byte_valid.
- Image format, all little-endian:
  - Bytes 0-1: word count N (16 bits).
  - Then 4*N bytes; each group of 4 bytes forms one word, first byte = bits 7:0.
- FSM states:
  - IDLE: load_en=0; cpu_hold=0, done=0, err=0. load_en rising → CNT_LO.
  - CNT_LO: cpu_hold=1; byte → N[7:0], go to CNT_HI.
  - CNT_HI: byte → N[15:8].
    - N=0 → DONE.
    - N > 2^ADDR_WIDTH → ERR.
    - Otherwise → DATA with address=0 and byte index=0.
  - DATA: each byte is shifted into the word assembler.
    - On the 4th byte, wr_en=1 in the next cycle, with wr_data = assembled word and wr_addr = current address.
    - The address increments after the write.
    - After the write at address N-1 → DONE.
  - DONE: cpu_hold=0, done=1. Further bytes are ignored. load_en=0 → IDLE.
  - ERR: cpu_hold=1, err=1. Bytes are ignored. load_en=0 → IDLE.
- A frame_err in any of CNT_LO, CNT_HI or DATA → ERR.
- load_en falling in any state → IDLE in the next cycle; a partially assembled word is discarded and no write occurs.
- wr_en is never asserted outside DATA. wr_addr and wr_data hold their last values between writes.
- Latency: stop-bit sample → byte_valid takes 1 cycle; byte_valid of the 4th byte → wr_en takes 1 cycle.
- If byte_valid and load_en falling coincide, the load_en fall takes priority and the byte is dropped.
- The address counter never wraps. The oversize check guarantees the last address is 2^ADDR_WIDTH-1.

Decomposition:
- Shared definitions header, added next to ISA_WIDTH:
  - loader state encodings (IDLE, CNT_LO, CNT_HI, DATA, DONE, ERR);
  - INST_ADDR_WIDTH = 14;
  - UART frame constants (8 data bits, 1 stop bit).
- One sub-module: uart_rx_byte (synchronizer, bit timer, shift register; outputs byte_valid, byte_data, frame_err).
- prog_loader itself contains the FSM, the word assembler and the address counter.

Test Plan:
- Bench settings: CLK_FREQ=16, BAUD=1 (16 clocks/bit).
- load_en=1, then bytes 02 00 | 78 56 34 12 | EF BE AD DE → wr_en pulses twice: (addr 0, 0x12345678) then (addr 1, 0xDEADBEEF). done=1 and cpu_hold=0 after the second write.
- Count bytes 00 00 → no wr_en, done=1 one cycle after the 2nd byte_valid; cpu_hold returns to 0.
- Count bytes 01 40 (N=16385) → err=1, cpu_hold=1, no writes. Dropping load_en → IDLE with err=0.
- N=1, send 2 data bytes, then a frame with stop bit=0 → err=1, no wr_en.
- N=1, send 3 data bytes, drop load_en, raise it again and send 01 00 AA BB CC DD → single write (addr 0, 0xDDCCBBAA); the stale bytes are not used.
- 0.25-bit low glitch on uart_rx, then reset asserted mid-frame → no byte_valid. After reset, all outputs are 0 and the state is IDLE.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: ISA/memory widths, UART frame
// shape and the state encodings of both the loader FSM and the byte receiver.
package prog_loader_pkg;

   localparam int ISA_WIDTH       = 32;
   localparam int INST_ADDR_WIDTH = 14;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_STOP_BITS  = 1;

   typedef enum logic [2:0] {
      IDLE,
      CNT_LO,
      CNT_HI,
      DATA,
      DONE,
      ERR
   } loader_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/prog_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling timer and
// shift register. Emits one-cycle byte_valid or frame_err pulses.
module uart_rx_byte
   import prog_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_i,
   output logic       byte_valid_o,
   output logic [7:0] byte_data_o,
   output logic       frame_err_o
);

   localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   rx_state_e                     state_q, state_d;
   logic [1:0]                    sync_q;
   logic                          rx_prev_q;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic [2:0]                    bit_q, bit_d;
   logic [UART_DATA_BITS-1:0]     shift_q, shift_d;
   logic                          valid_q, valid_d;
   logic                          ferr_q, ferr_d;
   logic                          rx_s;

   assign rx_s = sync_q[1];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q    <= 2'b11;
         rx_prev_q <= 1'b1;
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], rx_i};
         rx_prev_q <= rx_s;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (rx_prev_q && !rx_s) state_d = RX_START;
         end
         RX_START: begin
            // Line back high at mid start bit means it was a glitch.
            if (cnt_q == HALF) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == FULL) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'(UART_DATA_BITS - 1)) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt_q == FULL) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
               valid_d = rx_s;
               ferr_d  = !rx_s;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign byte_valid_o = valid_q;
   assign byte_data_o  = shift_q;
   assign frame_err_o  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a little-endian word-count + word image over UART
// and writes it into instruction memory while holding the CPU in reset.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115_200,
   parameter int ADDR_WIDTH = INST_ADDR_WIDTH,
   parameter int DATA_WIDTH = ISA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load_en,
   input  logic                  uart_rx,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  err
);

   localparam int               CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int               BYTES        = DATA_WIDTH / 8;
   localparam int               IDX_W        = $clog2(BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(BYTES - 1);
   localparam logic [16:0]      MAX_WORDS    = 17'(2 ** ADDR_WIDTH);

   loader_state_e         state_q, state_d;
   logic                  load_prev_q;
   logic [15:0]           count_q, count_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-9:0] asm_q, asm_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

   logic                  byte_valid;
   logic [7:0]            byte_data;
   logic                  frame_err;

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clock       (clock),
      .reset       (reset),
      .rx_i        (uart_rx),
      .byte_valid_o(byte_valid),
      .byte_data_o (byte_data),
      .frame_err_o (frame_err)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         load_prev_q <= 1'b0;
         count_q     <= '0;
         addr_q      <= '0;
         idx_q       <= '0;
         asm_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         load_prev_q <= load_en;
         count_q     <= count_d;
         addr_q      <= addr_d;
         idx_q       <= idx_d;
         asm_q       <= asm_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      addr_d    = addr_q;
      idx_d     = idx_q;
      asm_d     = asm_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      cpu_hold  = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (state_q)
         IDLE: begin
            idx_d = '0;
            if (load_en && !load_prev_q) state_d = CNT_LO;
         end
         CNT_LO: begin
            cpu_hold = 1'b1;
            if (frame_err) state_d = ERR;
            else if (byte_valid) begin
               count_d[7:0] = byte_data;
               state_d      = CNT_HI;
            end
         end
         CNT_HI: begin
            cpu_hold = 1'b1;
            if (frame_err) state_d = ERR;
            else if (byte_valid) begin
               count_d[15:8] = byte_data;
               addr_d        = '0;
               idx_d         = '0;
               if ({byte_data, count_q[7:0]} == 16'd0)                   state_d = DONE;
               else if ({1'b0, byte_data, count_q[7:0]} > MAX_WORDS)     state_d = ERR;
               else                                                      state_d = DATA;
            end
         end
         DATA: begin
            cpu_hold = 1'b1;
            if (frame_err) state_d = ERR;
            else if (wr_en_q && 16'(wr_addr_q) == count_q - 16'd1) state_d = DONE;
            else if (byte_valid) begin
               idx_d = idx_q + 1'b1;
               asm_d = {byte_data, asm_q[DATA_WIDTH-9:8]};
               if (idx_q == LAST_IDX) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = {byte_data, asm_q};
                  // Hold the address on the final word so it never wraps.
                  if (16'(addr_q) != count_q - 16'd1) addr_d = addr_q + 1'b1;
               end
            end
         end
         DONE: done = 1'b1;
         ERR: begin
            cpu_hold = 1'b1;
            err      = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      // Dropping load_en wins over any byte arriving in the same cycle.
      if (!load_en) begin
         state_d = IDLE;
         wr_en_d = 1'b0;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader at 16 clocks per UART bit; writes are
// checked against a scoreboard queue filled as each image is sent.
module tb_prog_loader;
   import prog_loader_pkg::*;

   localparam int CPB = 16;
   localparam int AW  = 14;
   localparam int DW  = 32;

   typedef logic [AW+DW-1:0] wr_t;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          load_en = 1'b0;
   logic          uart_rx = 1'b1;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          cpu_hold;
   logic          done;
   logic          err;

   wr_t exp_q[$];
   wr_t obs_q[$];
   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   int  bv_count = 0;
   int  last_bv_cyc = 0;
   int  last_wr_cyc = 0;
   int  done_rise_cyc = 0;
   logic done_prev = 1'b0;

   prog_loader #(
      .CLK_FREQ(16),
      .BAUD    (1)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .load_en (load_en),
      .uart_rx (uart_rx),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .cpu_hold(cpu_hold),
      .done    (done),
      .err     (err)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (wr_en === 1'b1) begin
         obs_q.push_back({wr_addr, wr_data});
         last_wr_cyc = cyc;
      end
      if (dut.u_rx.byte_valid_o === 1'b1) begin
         bv_count++;
         last_bv_cyc = cyc;
      end
      if (done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
      done_prev = done;
   end

   task automatic uart_send(input logic [7:0] b, input logic stop_bit);
      @(negedge clock);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clock);
      end
      uart_rx = stop_bit;
      repeat (CPB) @(negedge clock);
      uart_rx = 1'b1;
      repeat (2 * CPB) @(negedge clock);
   endtask

   task automatic start_load();
      @(negedge clock);
      load_en = 1'b1;
      repeat (3) @(negedge clock);
   endtask

   task automatic stop_load();
      @(negedge clock);
      load_en = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if ({wr_en, cpu_hold, done, err} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 0000", {wr_en, cpu_hold, done, err});
      end
      checks++;
      if ({wr_addr, wr_data} !== '0) begin
         failures++;
         $display("FAIL reset_wr_bus: got addr=%h data=%h expected 0", wr_addr, wr_data);
      end
      checks++;
      if (dut.state_q !== IDLE) begin
         failures++;
         $display("FAIL reset_state: got %0d expected IDLE", dut.state_q);
      end
      reset = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_basic();
      logic [7:0] img[10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                              8'hEF, 8'hBE, 8'hAD, 8'hDE};
      wr_t e, o;
      obs_q.delete();
      start_load();
      checks++;
      if (cpu_hold !== 1'b1) begin
         failures++;
         $display("FAIL basic_hold_during_load: got %b expected 1", cpu_hold);
      end
      exp_q.push_back({14'd0, 32'h12345678});
      exp_q.push_back({14'd1, 32'hDEADBEEF});
      foreach (img[i]) uart_send(img[i], 1'b1);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL basic_write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL basic_write: got addr=%h data=%h expected addr=%h data=%h",
                     o[AW+DW-1:DW], o[DW-1:0], e[AW+DW-1:DW], e[DW-1:0]);
         end
      end
      exp_q.delete();
      checks++;
      if (last_wr_cyc - last_bv_cyc !== 1) begin
         failures++;
         $display("FAIL basic_wr_latency: got %0d expected 1", last_wr_cyc - last_bv_cyc);
      end
      checks++;
      if ({done, cpu_hold, err} !== 3'b100) begin
         failures++;
         $display("FAIL basic_done: got done/hold/err=%b expected 100", {done, cpu_hold, err});
      end
      stop_load();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL basic_done_clear: got %b expected 0", done);
      end
   endtask

   task automatic test_zero_count();
      obs_q.delete();
      start_load();
      uart_send(8'h00, 1'b1);
      uart_send(8'h00, 1'b1);
      checks++;
      if (obs_q.size() !== 0) begin
         failures++;
         $display("FAIL zero_no_write: got %0d writes expected 0", obs_q.size());
      end
      checks++;
      if ({done, cpu_hold} !== 2'b10) begin
         failures++;
         $display("FAIL zero_done: got done/hold=%b expected 10", {done, cpu_hold});
      end
      checks++;
      if (done_rise_cyc - last_bv_cyc !== 1) begin
         failures++;
         $display("FAIL zero_done_latency: got %0d expected 1", done_rise_cyc - last_bv_cyc);
      end
      stop_load();
   endtask

   task automatic test_oversize();
      obs_q.delete();
      start_load();
      uart_send(8'h01, 1'b1);
      uart_send(8'h40, 1'b1);
      checks++;
      if ({err, cpu_hold, done} !== 3'b110) begin
         failures++;
         $display("FAIL oversize_err: got err/hold/done=%b expected 110", {err, cpu_hold, done});
      end
      checks++;
      if (obs_q.size() !== 0) begin
         failures++;
         $display("FAIL oversize_no_write: got %0d writes expected 0", obs_q.size());
      end
      stop_load();
      checks++;
      if ({err, cpu_hold} !== 2'b00 || dut.state_q !== IDLE) begin
         failures++;
         $display("FAIL oversize_clear: got err/hold=%b state=%0d expected 00 IDLE",
                  {err, cpu_hold}, dut.state_q);
      end
   endtask

   task automatic test_frame_err();
      obs_q.delete();
      start_load();
      uart_send(8'h01, 1'b1);
      uart_send(8'h00, 1'b1);
      uart_send(8'h11, 1'b1);
      uart_send(8'h22, 1'b1);
      uart_send(8'h33, 1'b0);
      checks++;
      if ({err, cpu_hold} !== 2'b11) begin
         failures++;
         $display("FAIL frame_err_flag: got err/hold=%b expected 11", {err, cpu_hold});
      end
      uart_send(8'h44, 1'b1);
      checks++;
      if (obs_q.size() !== 0 || err !== 1'b1) begin
         failures++;
         $display("FAIL frame_err_sticky: got writes=%0d err=%b expected 0 1", obs_q.size(), err);
      end
      stop_load();
   endtask

   task automatic test_abort_reload();
      logic [7:0] img[6] = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      wr_t e, o;
      obs_q.delete();
      start_load();
      uart_send(8'h01, 1'b1);
      uart_send(8'h00, 1'b1);
      uart_send(8'h11, 1'b1);
      uart_send(8'h22, 1'b1);
      uart_send(8'h33, 1'b1);
      stop_load();
      checks++;
      if (cpu_hold !== 1'b0 || dut.state_q !== IDLE) begin
         failures++;
         $display("FAIL abort_idle: got hold=%b state=%0d expected 0 IDLE", cpu_hold, dut.state_q);
      end
      start_load();
      exp_q.push_back({14'd0, 32'hDDCCBBAA});
      foreach (img[i]) uart_send(img[i], 1'b1);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL abort_write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL abort_write: got addr=%h data=%h expected addr=%h data=%h",
                     o[AW+DW-1:DW], o[DW-1:0], e[AW+DW-1:DW], e[DW-1:0]);
         end
      end
      exp_q.delete();
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL abort_done: got %b expected 1", done);
      end
   endtask

   task automatic test_glitch_reset();
      int bv_before;
      bv_before = bv_count;
      @(negedge clock);
      uart_rx = 1'b0;
      repeat (CPB / 4) @(negedge clock);
      uart_rx = 1'b1;
      repeat (3 * CPB) @(negedge clock);
      checks++;
      if (bv_count !== bv_before || dut.u_rx.state_q !== RX_IDLE) begin
         failures++;
         $display("FAIL glitch_ignored: got bytes=%0d rx_state=%0d expected %0d RX_IDLE",
                  bv_count, dut.u_rx.state_q, bv_before);
      end
      uart_rx = 1'b0;
      repeat (3 * CPB) @(negedge clock);
      #2 reset = 1'b0;
      uart_rx = 1'b1;
      load_en = 1'b0;
      @(negedge clock);
      checks++;
      if ({wr_en, cpu_hold, done, err} !== 4'b0000 || {wr_addr, wr_data} !== '0) begin
         failures++;
         $display("FAIL midframe_reset_outputs: got flags=%b addr=%h data=%h expected 0",
                  {wr_en, cpu_hold, done, err}, wr_addr, wr_data);
      end
      checks++;
      if (dut.state_q !== IDLE) begin
         failures++;
         $display("FAIL midframe_reset_state: got %0d expected IDLE", dut.state_q);
      end
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (12 * CPB) @(negedge clock);
      checks++;
      if (bv_count !== bv_before) begin
         failures++;
         $display("FAIL midframe_no_byte: got %0d bytes expected %0d", bv_count, bv_before);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_count();
      test_oversize();
      test_frame_err();
      test_abort_reload();
      test_glitch_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
